alu_bist: RTL and testbench
===========================

# alu_bist

Synthesizable built-in self-test checker for the execute stage's `alu_control` + `alu` pair. It drives the same 32-entry opcode/function-code sweep that the bench applies by hand. It waits for the combinational ALU response, compares `result`/`zero` against an internal golden model, and reports pass/fail counts and the first failing vector index. It sits beside the EX stage and is muxed onto the ALU inputs only while the pipeline is halted for debug.

## Interface
- `NB_REG`, 32, operand/result width
- `NB_OPCODE`, 6, opcode width
- `NB_FCODE`, 6, function-code width
- `N_VEC`, 32, number of sweep vectors (fixed list below; index width 5)

Ports:
- `i_clock`  in  1  clock
- `i_reset`  in  1  reset; synchronous and active-low
- `i_start`  in  1  start pulse; sampled in IDLE or DONE
- `i_a`, `i_b`  in  NB_REG  operands, latched on accepted start
- `i_result`  in  NB_REG  ALU `o_result`
- `i_zero`  in  1  ALU `o_zero`
- `o_opcode`  out  NB_OPCODE  to `alu_control.i_opcode`
- `o_funct_code`  out  NB_FCODE  to `alu_control.i_funct_code`
- `o_a`, `o_b`  out  NB_REG  to `alu.i_a`/`i_b`
- `o_busy`  out  1  sweep in progress
- `o_done`  out  1  sweep finished (sticky until restart/reset)
- `o_pass`  out  1  valid with `o_done`: fail count == 0
- `o_fail_count`  out  6  mismatching vectors
- `o_fail_valid`  out  1  at least one mismatch recorded
- `o_first_fail_idx`  out  5  index of first mismatch

## Operation
- Vector list:
  - Indices 0–14 are R-type (opcode 0x00), funct in this order: ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2a, SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07.
  - Indices 15–31 are opcodes BEQ 04, BNE 05, ADDI 08, SLTI 0a, ANDI 0c, ORI 0d, XORI 0e, LUI 0f, LB 20, LH 21, LHU 22, LW 23, LWU 24, LBU 25, SB 28, SH 29, SW 2b, with funct driven 0.
- Golden model, 32-bit two's complement with wrap and no overflow trap:
  - ADD/ADDU/ADDI/all loads and stores: a+b.
  - SUB/SUBU/BEQ/BNE: a−b.
  - AND/ANDI: a&b. OR/ORI: a|b. XOR/XORI: a^b. NOR: ~(a|b).
  - SLT/SLTI: signed a<b → 1, else 0.
  - All six shifts shift b by a[4:0]: SLL/SLLV logical left, SRL/SRLV logical right, SRA/SRAV arithmetic right.
  - LUI: b<<16.
  - Golden zero = (golden result == 0).
- A vector fails if `i_result` ≠ golden result or `i_zero` ≠ golden zero.
- FSM:
  - IDLE: on `i_start`, latch operands, clear counters and flags, set index=0, go to DRIVE.
  - DRIVE: register `o_opcode`/`o_funct_code`/`o_a`/`o_b` for the current index, go to CHECK.
  - CHECK: compare and update counters. If index==31, go to DONE; otherwise increment index and go to DRIVE.
  - DONE: hold results. `i_start` restarts exactly as from IDLE.
- On a mismatch:
  - `o_fail_count` increments, saturating at 63.
  - `o_first_fail_idx` is written only when `o_fail_valid` was 0; then `o_fail_valid` is set.
- `i_start` is ignored in DRIVE and CHECK.

## Timing
- Reset values: every output 0, FSM in IDLE, index 0.
- Call the start-sampling edge cycle 0. DRIVE of vector k occurs in cycle 2k+1; its CHECK occurs in cycle 2k+2.
- The ALU path must be combinational within one cycle.
- `o_busy` is 1 from cycle 1 through cycle 64.
- In cycle 65: `o_done`=1, `o_busy`=0, and `o_pass` is valid.
- Operand outputs remain stable between DRIVE and CHECK of the same vector.
- Reset asserted mid-sweep: the next edge returns the block to IDLE with all outputs 0. No partial results are retained.
- Simultaneous `i_start` and reset: reset wins.

## Configuration
- `ALU_BIST_STOP_ON_FAIL_EN`
  - Defined: the first mismatch in CHECK goes directly to DONE. `o_fail_count`=1, and `o_pass`=0.
  - Undefined: the full 32-vector sweep always runs, and the count is the total number of mismatches.

## Test plan
- Real `alu_control`+`alu`, `i_a`=2, `i_b`=1, start → `o_done` at cycle 65, `o_pass`=1, `o_fail_count`=0, `o_fail_valid`=0.
- Mock ALU that always returns result 0 with zero=1, a=2, b=1, macro undefined → `o_fail_count`=24, `o_first_fail_idx`=0. Only AND, SLT, SRL, SRA, SRLV, SRAV, SLTI and ANDI pass.
- Same mock with `ALU_BIST_STOP_ON_FAIL_EN` defined → `o_done` at cycle 3, `o_fail_count`=1, `o_first_fail_idx`=0.
- Real ALU, a=0x0000_0004, b=0x8000_0000 → pass. Spot-check at CHECK: SRA vector expects 0xF800_0000; SLT expects 0 (b is negative); LUI expects 0.
- Reset pulse at cycle 20 of a sweep → all outputs 0 on the next cycle; a new start then completes normally at start+65.
- `i_start` pulsed during cycle 10 of a sweep → ignored, `o_done` still at cycle 65. A start in DONE restarts and clears counters.

Source files
------------

// File: rtl/alu_bist.sv
// Built-in self-test sweep for the alu_control + alu pair: drives 32 fixed vectors, checks
// result/zero against a golden model. Optional build macro: ALU_BIST_STOP_ON_FAIL_EN.
module alu_bist #(
    parameter int unsigned NB_REG    = 32,
    parameter int unsigned NB_OPCODE = 6,
    parameter int unsigned NB_FCODE  = 6,
    parameter int unsigned N_VEC     = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_REG-1:0]    i_a,
    input  logic [NB_REG-1:0]    i_b,
    input  logic [NB_REG-1:0]    i_result,
    input  logic                 i_zero,
    output logic [NB_OPCODE-1:0] o_opcode,
    output logic [NB_FCODE-1:0]  o_funct_code,
    output logic [NB_REG-1:0]    o_a,
    output logic [NB_REG-1:0]    o_b,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [5:0]           o_fail_count,
    output logic                 o_fail_valid,
    output logic [4:0]           o_first_fail_idx
);

    localparam logic [4:0] LastIdx  = 5'(N_VEC - 1);
    localparam logic [5:0] CountMax = 6'd63;

    typedef enum logic [1:0] {StIdle, StDrive, StCheck, StDone} state_e;

    typedef enum logic [3:0] {
        OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSlt, OpSll, OpSrl, OpSra, OpLui
    } op_e;

    typedef struct packed {
        logic [NB_OPCODE-1:0] opcode;
        logic [NB_FCODE-1:0]  funct;
        op_e                  op;
    } vec_t;

    // Sweep table: 0-14 R-type by funct, 15-31 I-type/branch/memory by opcode.
    function automatic vec_t vec_lookup(input logic [4:0] idx);
        vec_t v;
        v.opcode = '0;
        v.funct  = '0;
        v.op     = OpAdd;
        case (idx)
            5'd0:  begin v.funct = NB_FCODE'(6'h20); v.op = OpAdd; end
            5'd1:  begin v.funct = NB_FCODE'(6'h21); v.op = OpAdd; end
            5'd2:  begin v.funct = NB_FCODE'(6'h22); v.op = OpSub; end
            5'd3:  begin v.funct = NB_FCODE'(6'h23); v.op = OpSub; end
            5'd4:  begin v.funct = NB_FCODE'(6'h24); v.op = OpAnd; end
            5'd5:  begin v.funct = NB_FCODE'(6'h25); v.op = OpOr;  end
            5'd6:  begin v.funct = NB_FCODE'(6'h26); v.op = OpXor; end
            5'd7:  begin v.funct = NB_FCODE'(6'h27); v.op = OpNor; end
            5'd8:  begin v.funct = NB_FCODE'(6'h2a); v.op = OpSlt; end
            5'd9:  begin v.funct = NB_FCODE'(6'h00); v.op = OpSll; end
            5'd10: begin v.funct = NB_FCODE'(6'h02); v.op = OpSrl; end
            5'd11: begin v.funct = NB_FCODE'(6'h03); v.op = OpSra; end
            5'd12: begin v.funct = NB_FCODE'(6'h04); v.op = OpSll; end
            5'd13: begin v.funct = NB_FCODE'(6'h06); v.op = OpSrl; end
            5'd14: begin v.funct = NB_FCODE'(6'h07); v.op = OpSra; end
            5'd15: begin v.opcode = NB_OPCODE'(6'h04); v.op = OpSub; end
            5'd16: begin v.opcode = NB_OPCODE'(6'h05); v.op = OpSub; end
            5'd17: begin v.opcode = NB_OPCODE'(6'h08); v.op = OpAdd; end
            5'd18: begin v.opcode = NB_OPCODE'(6'h0a); v.op = OpSlt; end
            5'd19: begin v.opcode = NB_OPCODE'(6'h0c); v.op = OpAnd; end
            5'd20: begin v.opcode = NB_OPCODE'(6'h0d); v.op = OpOr;  end
            5'd21: begin v.opcode = NB_OPCODE'(6'h0e); v.op = OpXor; end
            5'd22: begin v.opcode = NB_OPCODE'(6'h0f); v.op = OpLui; end
            5'd23: begin v.opcode = NB_OPCODE'(6'h20); v.op = OpAdd; end
            5'd24: begin v.opcode = NB_OPCODE'(6'h21); v.op = OpAdd; end
            5'd25: begin v.opcode = NB_OPCODE'(6'h22); v.op = OpAdd; end
            5'd26: begin v.opcode = NB_OPCODE'(6'h23); v.op = OpAdd; end
            5'd27: begin v.opcode = NB_OPCODE'(6'h24); v.op = OpAdd; end
            5'd28: begin v.opcode = NB_OPCODE'(6'h25); v.op = OpAdd; end
            5'd29: begin v.opcode = NB_OPCODE'(6'h28); v.op = OpAdd; end
            5'd30: begin v.opcode = NB_OPCODE'(6'h29); v.op = OpAdd; end
            default: begin v.opcode = NB_OPCODE'(6'h2b); v.op = OpAdd; end
        endcase
        return v;
    endfunction

    state_e               state_q, state_d;
    logic [4:0]           idx_q, idx_d;
    logic [NB_REG-1:0]    a_q, a_d, b_q, b_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_FCODE-1:0]  funct_q, funct_d;
    logic [NB_REG-1:0]    drv_a_q, drv_a_d, drv_b_q, drv_b_d;
    logic [5:0]           fail_count_q, fail_count_d;
    logic                 fail_valid_q, fail_valid_d;
    logic [4:0]           first_fail_q, first_fail_d;

    vec_t              cur_vec;
    logic [NB_REG-1:0] golden;
    logic              golden_zero;
    logic              mismatch;
    logic              last_vec;
    logic              start_ok;

    assign cur_vec  = vec_lookup(idx_q);
    assign last_vec = (idx_q == LastIdx);
    assign start_ok = i_start && ((state_q == StIdle) || (state_q == StDone));

    // Golden model works from the latched operands; idx is stable across DRIVE and CHECK.
    always_comb begin
        golden = '0;
        unique case (cur_vec.op)
            OpAdd: golden = a_q + b_q;
            OpSub: golden = a_q - b_q;
            OpAnd: golden = a_q & b_q;
            OpOr:  golden = a_q | b_q;
            OpXor: golden = a_q ^ b_q;
            OpNor: golden = ~(a_q | b_q);
            OpSlt: golden = {{(NB_REG - 1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OpSll: golden = b_q << a_q[4:0];
            OpSrl: golden = b_q >> a_q[4:0];
            OpSra: golden = $unsigned($signed(b_q) >>> a_q[4:0]);
            OpLui: golden = b_q << 16;
            default: golden = '0;
        endcase
    end

    assign golden_zero = (golden == '0);
    assign mismatch    = (i_result != golden) || (i_zero != golden_zero);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) state_d = StDrive;
            end
            StDrive: state_d = StCheck;
            StCheck: begin
`ifdef ALU_BIST_STOP_ON_FAIL_EN
                if (mismatch || last_vec) state_d = StDone;
                else                      state_d = StDrive;
`else
                if (last_vec) state_d = StDone;
                else          state_d = StDrive;
`endif
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            opcode_q     <= '0;
            funct_q      <= '0;
            drv_a_q      <= '0;
            drv_b_q      <= '0;
            fail_count_q <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            opcode_q     <= opcode_d;
            funct_q      <= funct_d;
            drv_a_q      <= drv_a_d;
            drv_b_q      <= drv_b_d;
            fail_count_q <= fail_count_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
        end
    end

    always_comb begin
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        opcode_d     = opcode_q;
        funct_d      = funct_q;
        drv_a_d      = drv_a_q;
        drv_b_d      = drv_b_q;
        fail_count_d = fail_count_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    a_d          = i_a;
                    b_d          = i_b;
                    idx_d        = '0;
                    fail_count_d = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                end
            end
            StDrive: begin
                opcode_d = cur_vec.opcode;
                funct_d  = cur_vec.funct;
                drv_a_d  = a_q;
                drv_b_d  = b_q;
            end
            StCheck: begin
                if (mismatch) begin
                    if (fail_count_q != CountMax) fail_count_d = fail_count_q + 6'd1;
                    if (!fail_valid_q) begin
                        first_fail_d = idx_q;
                        fail_valid_d = 1'b1;
                    end
                end
                if (!last_vec) idx_d = idx_q + 5'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_opcode         = opcode_q;
        o_funct_code     = funct_q;
        o_a              = drv_a_q;
        o_b              = drv_b_q;
        o_busy           = (state_q == StDrive) || (state_q == StCheck);
        o_done           = (state_q == StDone);
        o_pass           = (state_q == StDone) && (fail_count_q == '0);
        o_fail_count     = fail_count_q;
        o_fail_valid     = fail_valid_q;
        o_first_fail_idx = first_fail_q;
    end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: a behavioural ALU (optionally faulty or mocked) closes the
// loop, and expected counts/indices/timing come from a mnemonic-level reference.
module tb_alu_bist;

    typedef enum int {KAdd, KSub, KAnd, KOr, KXor, KNor, KSlt, KSll, KSrl, KSra, KLui} kind_e;

`ifdef ALU_BIST_STOP_ON_FAIL_EN
    localparam bit StopOnFail = 1'b1;
`else
    localparam bit StopOnFail = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_a = '0, i_b = '0;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [5:0]  o_opcode, o_funct_code;
    logic [31:0] o_a, o_b;
    logic        o_busy, o_done, o_pass, o_fail_valid;
    logic [5:0]  o_fail_count;
    logic [4:0]  o_first_fail_idx;

    int n_cmp = 0;
    int n_bad = 0;

    kind_e vkind [32] = '{KAdd, KAdd, KSub, KSub, KAnd, KOr, KXor, KNor, KSlt, KSll, KSrl, KSra,
                          KSll, KSrl, KSra, KSub, KSub, KAdd, KSlt, KAnd, KOr, KXor, KLui,
                          KAdd, KAdd, KAdd, KAdd, KAdd, KAdd, KAdd, KAdd, KAdd};
    logic [5:0] vop [32] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04, 6'h05, 6'h08,
                             6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h21, 6'h22, 6'h23,
                             6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};
    logic [5:0] vfn [32] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a,
                             6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                             6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    // ALU behaviour: 0 = correct (with per-vector faults), 1 = mock returning 0 / zero=1.
    int alu_mode = 0;
    int fault_kind [32];
    int fault_bit = 0;
    int hit;

    logic [5:0]  snap_op [32];
    logic [5:0]  snap_fn [32];
    logic [31:0] snap_a  [32];
    logic [31:0] snap_b  [32];

    always #5 clk = ~clk;

    alu_bist dut (
        .i_clock         (clk),
        .i_reset         (i_reset),
        .i_start         (i_start),
        .i_a             (i_a),
        .i_b             (i_b),
        .i_result        (alu_result),
        .i_zero          (alu_zero),
        .o_opcode        (o_opcode),
        .o_funct_code    (o_funct_code),
        .o_a             (o_a),
        .o_b             (o_b),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .o_pass          (o_pass),
        .o_fail_count    (o_fail_count),
        .o_fail_valid    (o_fail_valid),
        .o_first_fail_idx(o_first_fail_idx)
    );

    function automatic logic [31:0] ref_result(input kind_e k, input logic [31:0] a, b);
        case (k)
            KAdd: return a + b;
            KSub: return a - b;
            KAnd: return a & b;
            KOr:  return a | b;
            KXor: return a ^ b;
            KNor: return ~(a | b);
            KSlt: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            KSll: return b << a[4:0];
            KSrl: return b >> a[4:0];
            KSra: return $unsigned($signed(b) >>> a[4:0]);
            default: return b << 16;
        endcase
    endfunction

    always_comb begin
        hit = -1;
        for (int i = 0; i < 32; i++) if (vop[i] == o_opcode && vfn[i] == o_funct_code) hit = i;
        alu_result = '0;
        alu_zero   = 1'b1;
        if (alu_mode == 0 && hit >= 0) begin
            alu_result = ref_result(vkind[hit], o_a, o_b);
            alu_zero   = (alu_result == '0);
            if (fault_kind[hit] == 1) alu_result = alu_result ^ (32'h1 << fault_bit);
            if (fault_kind[hit] == 2) alu_zero = ~alu_zero;
        end
    end

    // Reference: which vectors the attached ALU gets wrong, and what the DUT should report.
    task automatic expect_of(input logic [31:0] a, b, output int cnt, output int first,
                             output int done_cyc);
        int total = 0;
        first = 0;
        for (int k = 0; k < 32; k++) begin
            bit bad = (alu_mode == 1) ? (ref_result(vkind[k], a, b) != 0) : (fault_kind[k] != 0);
            if (bad) begin
                if (total == 0) first = k;
                total++;
            end
        end
        if (StopOnFail && total > 0) begin
            cnt      = 1;
            done_cyc = 2 * first + 3;
        end else begin
            cnt      = total;
            done_cyc = 65;
        end
    endtask

    task automatic clear_faults();
        for (int k = 0; k < 32; k++) fault_kind[k] = 0;
    endtask

    // Start on edge 0, then sample each following cycle just before its closing edge.
    task automatic run_sweep(input logic [31:0] a, b, input int pulse_cyc,
                             input logic [31:0] pa, pb, output int done_cyc,
                             output int busy_bad, output int stable_bad);
        @(negedge clk);
        i_a = a;
        i_b = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        done_cyc = -1;
        busy_bad = 0;
        stable_bad = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (o_done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            if (o_busy !== 1'b1) busy_bad++;
            if (cyc >= 2 && cyc % 2 == 0) begin
                snap_op[(cyc - 2) / 2] = o_opcode;
                snap_fn[(cyc - 2) / 2] = o_funct_code;
                snap_a[(cyc - 2) / 2]  = o_a;
                snap_b[(cyc - 2) / 2]  = o_b;
            end
            if (cyc >= 3 && cyc % 2 == 1) begin
                int k = (cyc - 3) / 2;
                if (o_opcode !== snap_op[k] || o_funct_code !== snap_fn[k] ||
                    o_a !== snap_a[k] || o_b !== snap_b[k]) stable_bad++;
            end
            if (cyc == pulse_cyc) begin
                i_a = pa;
                i_b = pb;
                i_start = 1'b1;
            end else begin
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({o_opcode, o_funct_code, o_a, o_b} !== '0) begin
            n_bad++;
            $display("FAIL reset_vec_outs: got %h/%h/%h/%h want 0", o_opcode, o_funct_code, o_a, o_b);
        end
        n_cmp++;
        if ({o_busy, o_done, o_pass, o_fail_valid, o_fail_count, o_first_fail_idx} !== '0) begin
            n_bad++;
            $display("FAIL reset_status: busy %b done %b pass %b fv %b fc %0d ffi %0d want all 0",
                     o_busy, o_done, o_pass, o_fail_valid, o_fail_count, o_first_fail_idx);
        end
        i_reset = 1'b1;
    endtask

    task automatic test_sweep(input string name, input logic [31:0] a, b);
        int dc, bb, sb, ecnt, efirst, edc;
        expect_of(a, b, ecnt, efirst, edc);
        run_sweep(a, b, -1, '0, '0, dc, bb, sb);
        n_cmp++;
        if (dc != edc) begin
            n_bad++;
            $display("FAIL %s_done_cycle: got %0d want %0d", name, dc, edc);
        end
        n_cmp++;
        if (o_fail_count !== 6'(ecnt) || o_pass !== (ecnt == 0)) begin
            n_bad++;
            $display("FAIL %s_count: got %0d pass %b want %0d", name, o_fail_count, o_pass, ecnt);
        end
        n_cmp++;
        if (o_fail_valid !== (ecnt != 0) || (ecnt != 0 && o_first_fail_idx !== 5'(efirst))) begin
            n_bad++;
            $display("FAIL %s_first: got v%b idx %0d want v%b idx %0d", name, o_fail_valid,
                     o_first_fail_idx, ecnt != 0, efirst);
        end
        n_cmp++;
        if (bb != 0 || sb != 0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_busy_stable: got busy_gaps %0d unstable %0d busy %b want 0 0 0",
                     name, bb, sb, o_busy);
        end
        n_cmp++;
        begin
            int wrong = 0;
            for (int k = 0; k < (edc - 1) / 2; k++)
                if (snap_op[k] !== vop[k] || snap_fn[k] !== vfn[k] ||
                    snap_a[k] !== a || snap_b[k] !== b) wrong++;
            if (wrong != 0) begin
                n_bad++;
                $display("FAIL %s_drive_vectors: got %0d wrong vectors want 0", name, wrong);
            end
        end
    endtask

    task automatic test_spot();
        alu_mode = 0;
        clear_faults();
        test_sweep("spot_neg_b", 32'h0000_0004, 32'h8000_0000);
        n_cmp++;
        if (snap_fn[11] !== 6'h03 || snap_a[11] !== 32'h4 || snap_b[11] !== 32'h8000_0000) begin
            n_bad++;
            $display("FAIL spot_sra_drive: got fn %h a %h b %h want 03 4 80000000",
                     snap_fn[11], snap_a[11], snap_b[11]);
        end
    endtask

    task automatic test_random_faults();
        for (int it = 0; it < 5; it++) begin
            logic [31:0] a = $urandom;
            logic [31:0] b = $urandom;
            alu_mode = 0;
            fault_bit = $urandom_range(0, 31);
            for (int k = 0; k < 32; k++)
                fault_kind[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
            test_sweep("rand_fault", a, b);
        end
        clear_faults();
    endtask

    task automatic test_reset_mid();
        int dc, bb, sb;
        alu_mode = 1;
        @(negedge clk);
        i_a = 32'd2;
        i_b = 32'd1;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (19) @(negedge clk);
        n_cmp++;
        if (o_fail_valid !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_partial: got fv %b busy %b want 1 1", o_fail_valid, o_busy);
        end
        i_reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({o_opcode, o_funct_code, o_a, o_b, o_busy, o_done, o_pass, o_fail_valid,
             o_fail_count, o_first_fail_idx} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_clear: got fc %0d fv %b busy %b a %h want all 0",
                     o_fail_count, o_fail_valid, o_busy, o_a);
        end
        i_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_beats_start: got busy %b done %b want 0 0", o_busy, o_done);
        end
        i_start = 1'b0;
        i_reset = 1'b1;
        alu_mode = 0;
        run_sweep(32'd2, 32'd1, -1, '0, '0, dc, bb, sb);
        n_cmp++;
        if (dc != 65 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset_sweep: got done %0d pass %b want 65 1", dc, o_pass);
        end
    endtask

    task automatic test_start_ignored();
        int dc, bb, sb, ecnt, efirst, edc;
        alu_mode = 1;
        expect_of(32'd2, 32'd1, ecnt, efirst, edc);
        run_sweep(32'd2, 32'd1, 10, 32'd0, 32'd0, dc, bb, sb);
        n_cmp++;
        if (dc != edc || o_fail_count !== 6'(ecnt) || o_first_fail_idx !== 5'(efirst)) begin
            n_bad++;
            $display("FAIL start_ignored: got done %0d fc %0d ffi %0d want %0d %0d %0d",
                     dc, o_fail_count, o_first_fail_idx, edc, ecnt, efirst);
        end
        alu_mode = 0;
        run_sweep(32'd7, 32'd3, -1, '0, '0, dc, bb, sb);
        n_cmp++;
        if (dc != 65 || o_fail_count !== 6'd0 || o_fail_valid !== 1'b0 || o_pass !== 1'b1) begin
            n_bad++;
            $display("FAIL restart_clears: got done %0d fc %0d fv %b pass %b want 65 0 0 1",
                     dc, o_fail_count, o_fail_valid, o_pass);
        end
    endtask

    initial begin
        clear_faults();
        test_reset();
        alu_mode = 0;
        test_sweep("basic_pass", 32'd2, 32'd1);
        alu_mode = 1;
        test_sweep("mock_zero", 32'd2, 32'd1);
        test_spot();
        test_random_faults();
        test_reset_mid();
        test_start_ignored();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
